// File: rtl/uart_debug_parser.sv
// uart_debug_parser: UART RX front end that parses "R/W addr [data]" text lines into FIFO write records
module uart_debug_parser #(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 115200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rxd,
    input  logic        full,
    output logic        w_req,
    output logic        w_rnw,
    output logic [31:0] w_addr,
    output logic [31:0] w_data,
    output logic        err,
    output logic        ovf
);
    localparam int DIV  = CLK_HZ / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV + 1);

    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rstate_t;
    typedef enum logic [2:0] {IDLE, SP1, ADDR, DATA, SKIP} pstate_t;

    logic          s1, rx, rx_d;
    rstate_t       rs, rs_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bitn, bit_n;
    logic [7:0]    sh, sh_n;
    logic          bv, bv_n, ferr, ferr_n;

    pstate_t       ps, ps_n;
    logic          rnw, rnw_n;
    logic [31:0]   addr, addr_n, data, data_n;
    logic [3:0]    nd, nd_n;
    logic          done, perr;
    logic          hex, is_cmd, is_sp, is_us, is_term;
    logic [3:0]    nib;

    // synchronizer, edge history and all receiver/parser state
    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b1;
            rx   <= 1'b1;
            rx_d <= 1'b1;
            rs   <= R_IDLE;
            cnt  <= '0;
            bitn <= '0;
            sh   <= '0;
            bv   <= 1'b0;
            ferr <= 1'b0;
            ps   <= IDLE;
            rnw  <= 1'b0;
            addr <= '0;
            data <= '0;
            nd   <= '0;
        end else begin
            s1   <= uart_rxd;
            rx   <= s1;
            rx_d <= rx;
            rs   <= rs_n;
            cnt  <= cnt_n;
            bitn <= bit_n;
            sh   <= sh_n;
            bv   <= bv_n;
            ferr <= ferr_n;
            ps   <= ps_n;
            rnw  <= rnw_n;
            addr <= addr_n;
            data <= data_n;
            nd   <= nd_n;
        end
    end

    // receiver: start validation at mid-bit, 8 data bits LSB first, stop-bit check
    always_comb begin
        rs_n   = rs;
        cnt_n  = cnt + 1'b1;
        bit_n  = bitn;
        sh_n   = sh;
        bv_n   = 1'b0;
        ferr_n = 1'b0;
        case (rs)
            R_IDLE: begin
                cnt_n = '0;
                rs_n  = (rx_d && !rx) ? R_START : R_IDLE;
            end
            R_START: if (cnt == CW'(HALF - 1)) begin
                rs_n  = rx ? R_IDLE : R_DATA;
                cnt_n = '0;
                bit_n = '0;
            end
            R_DATA: if (cnt == CW'(DIV - 1)) begin
                sh_n  = {rx, sh[7:1]};
                cnt_n = '0;
                bit_n = bitn + 1'b1;
                rs_n  = (bitn == 3'd7) ? R_STOP : R_DATA;
            end
            R_STOP: if (cnt == CW'(DIV - 1)) begin
                bv_n   = rx;
                ferr_n = !rx;
                rs_n   = rx ? R_IDLE : R_WAIT;
            end
            R_WAIT: rs_n = rx ? R_IDLE : R_WAIT;
            default: rs_n = R_IDLE;
        endcase
    end

    // character classification of the received byte
    always_comb begin
        hex     = (sh >= 8'h30 && sh <= 8'h39) || (sh >= 8'h41 && sh <= 8'h46) || (sh >= 8'h61 && sh <= 8'h66);
        nib     = (sh <= 8'h39) ? sh[3:0] : sh[3:0] + 4'd9;
        is_cmd  = sh == 8'h52 || sh == 8'h72 || sh == 8'h57 || sh == 8'h77;
        is_sp   = sh == 8'h20;
        is_us   = sh == 8'h5F;
        is_term = sh == 8'h0D || sh == 8'h0A;
    end

    // line parser: fields accumulate nibble-wise, any violation skips to end of line
    always_comb begin
        ps_n   = ps;
        rnw_n  = rnw;
        addr_n = addr;
        data_n = data;
        nd_n   = nd;
        done   = 1'b0;
        perr   = 1'b0;
        if (ferr) begin
            ps_n = SKIP;
        end else if (bv) begin
            case (ps)
                IDLE: if (is_cmd) begin
                    rnw_n  = sh == 8'h52 || sh == 8'h72;
                    addr_n = '0;
                    data_n = '0;
                    nd_n   = '0;
                    ps_n   = SP1;
                end else if (!is_term) begin
                    perr = 1'b1;
                    ps_n = SKIP;
                end
                SP1: begin
                    perr = !is_sp;
                    ps_n = is_sp ? ADDR : SKIP;
                end
                ADDR: if (hex && nd != 4'd8) begin
                    addr_n = {addr[27:0], nib};
                    nd_n   = nd + 1'b1;
                end else if (is_sp && nd != 4'd0) begin
                    nd_n = '0;
                    ps_n = DATA;
                end else if (is_term && rnw && nd != 4'd0) begin
                    done = 1'b1;
                    ps_n = IDLE;
                end else if (!is_us) begin
                    perr = 1'b1;
                    ps_n = SKIP;
                end
                DATA: if (hex && nd != 4'd8) begin
                    data_n = {data[27:0], nib};
                    nd_n   = nd + 1'b1;
                end else if (is_term && nd != 4'd0) begin
                    done = 1'b1;
                    ps_n = IDLE;
                end else if (!is_us) begin
                    perr = 1'b1;
                    ps_n = SKIP;
                end
                SKIP: ps_n = is_term ? IDLE : SKIP;
                default: ps_n = IDLE;
            endcase
        end
    end

    // registered record and status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            w_req  <= 1'b0;
            ovf    <= 1'b0;
            err    <= 1'b0;
            w_rnw  <= 1'b0;
            w_addr <= '0;
            w_data <= '0;
        end else begin
            w_req <= done && !full;
            ovf   <= done && full;
            err   <= perr || ferr;
            if (done) begin
                w_rnw  <= rnw;
                w_addr <= addr;
                w_data <= data;
            end
        end
    end
endmodule

// File: tb/tb_uart_debug_parser.sv
// tb_uart_debug_parser: directed line-level tests of the UART debug command parser
module tb_uart_debug_parser;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uart_rxd = 1'b1;
    logic        full = 1'b0;
    logic        w_req, w_rnw, err, ovf;
    logic [31:0] w_addr, w_data;

    int total = 0;
    int bad = 0;
    int nreq = 0;
    int nerr = 0;
    int novf = 0;
    logic        rec_rnw [64];
    logic [31:0] rec_a   [64];
    logic [31:0] rec_d   [64];

    uart_debug_parser #(.CLK_HZ(100), .BAUD(10)) dut (
        .clk(clk), .rst(rst), .uart_rxd(uart_rxd), .full(full),
        .w_req(w_req), .w_rnw(w_rnw), .w_addr(w_addr), .w_data(w_data),
        .err(err), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // record every output pulse away from the active edge
    always @(negedge clk) begin
        if (w_req && nreq < 64) begin
            rec_rnw[nreq] = w_rnw;
            rec_a[nreq]   = w_addr;
            rec_d[nreq]   = w_data;
        end
        if (w_req) nreq = nreq + 1;
        if (err) nerr = nerr + 1;
        if (ovf) novf = novf + 1;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic v);
        uart_rxd = v;
        idle(10);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
        uart_rxd = 1'b1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
        idle(20);
    endtask

    task automatic check_rec(input string name, input int idx, input logic r, input logic [31:0] a, input logic [31:0] d);
        total++;
        if ({rec_rnw[idx], rec_a[idx], rec_d[idx]} !== {r, a, d}) begin
            bad++;
            $display("FAIL %s got=(%0b,%h,%h) exp=(%0b,%h,%h)", name, rec_rnw[idx], rec_a[idx], rec_d[idx], r, a, d);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle(5);
        total++;
        if ({w_req, w_rnw, w_addr, w_data, err, ovf} !== 68'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=0", {w_req, w_rnw, w_addr, w_data, err, ovf});
        end
        rst = 1'b0;
        idle(20);
    endtask

    task automatic test_write;
        int r0 = nreq;
        int e0 = nerr;
        send_str("W 0000_0010 DEAD_BEEF\r");
        total++;
        if (nreq - r0 !== 1) begin bad++; $display("FAIL write_count got=%0d exp=1", nreq - r0); end
        check_rec("write_rec", r0, 1'b0, 32'h10, 32'hDEADBEEF);
        total++;
        if (nerr - e0 !== 0) begin bad++; $display("FAIL write_err got=%0d exp=0", nerr - e0); end
    endtask

    task automatic test_back_to_back_reads;
        int r0 = nreq;
        int e0 = nerr;
        send_str("r 1234abcd\r\n");
        send_str("R 0000_0004 CAFE_F00D\r");
        total++;
        if (nreq - r0 !== 2) begin bad++; $display("FAIL read_count got=%0d exp=2", nreq - r0); end
        check_rec("read_rec0", r0, 1'b1, 32'h1234ABCD, 32'h0);
        check_rec("read_rec1", r0 + 1, 1'b1, 32'h4, 32'hCAFEF00D);
        total++;
        if (nerr - e0 !== 0) begin bad++; $display("FAIL read_err got=%0d exp=0", nerr - e0); end
    endtask

    task automatic test_parse_errors;
        int r0 = nreq;
        int e0 = nerr;
        send_str("W 123456789 1\r");
        send_str("X 1\r");
        total++;
        if (nerr - e0 !== 2) begin bad++; $display("FAIL parse_err_count got=%0d exp=2", nerr - e0); end
        total++;
        if (nreq - r0 !== 0) begin bad++; $display("FAIL parse_err_req got=%0d exp=0", nreq - r0); end
        send_str("W 1 2\r");
        total++;
        if (nreq - r0 !== 1) begin bad++; $display("FAIL recover_count got=%0d exp=1", nreq - r0); end
        check_rec("recover_rec", r0, 1'b0, 32'h1, 32'h2);
    endtask

    task automatic test_framing;
        int r0 = nreq;
        int e0 = nerr;
        send_byte("W", 1'b1);
        send_byte(" ", 1'b1);
        send_byte("1", 1'b1);
        send_byte(8'h41, 1'b0);
        idle(15);
        send_str("\r");
        total++;
        if (nerr - e0 !== 1) begin bad++; $display("FAIL frame_err got=%0d exp=1", nerr - e0); end
        total++;
        if (nreq - r0 !== 0) begin bad++; $display("FAIL frame_req got=%0d exp=0", nreq - r0); end
        send_str("W A B\r");
        total++;
        if (nreq - r0 !== 1) begin bad++; $display("FAIL frame_recover got=%0d exp=1", nreq - r0); end
        check_rec("frame_rec", r0, 1'b0, 32'hA, 32'hB);
    endtask

    task automatic test_full;
        int r0 = nreq;
        int o0 = novf;
        full = 1'b1;
        send_str("W 5 6\r");
        total++;
        if (novf - o0 !== 1) begin bad++; $display("FAIL ovf_count got=%0d exp=1", novf - o0); end
        total++;
        if (nreq - r0 !== 0) begin bad++; $display("FAIL ovf_req got=%0d exp=0", nreq - r0); end
        total++;
        if ({w_addr, w_data} !== {32'h5, 32'h6}) begin bad++; $display("FAIL ovf_regs got=%h exp=%h", {w_addr, w_data}, {32'h5, 32'h6}); end
        full = 1'b0;
        send_str("W 7 8\r");
        total++;
        if (nreq - r0 !== 1 || novf - o0 !== 1) begin bad++; $display("FAIL after_full got=req%0d/ovf%0d exp=req1/ovf1", nreq - r0, novf - o0); end
        check_rec("after_full_rec", r0, 1'b0, 32'h7, 32'h8);
    endtask

    task automatic test_glitch_reset;
        int r0 = nreq;
        int e0 = nerr;
        uart_rxd = 1'b0;
        idle(3);
        uart_rxd = 1'b1;
        idle(30);
        total++;
        if (nerr - e0 !== 0 || nreq - r0 !== 0) begin bad++; $display("FAIL glitch got=err%0d/req%0d exp=err0/req0", nerr - e0, nreq - r0); end
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        rst = 1'b1;
        idle(1);
        total++;
        if ({w_req, w_rnw, w_addr, w_data, err, ovf} !== 68'd0) begin
            bad++;
            $display("FAIL midreset_outputs got=%h exp=0", {w_req, w_rnw, w_addr, w_data, err, ovf});
        end
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        uart_rxd = 1'b1;
        idle(5);
        rst = 1'b0;
        idle(30);
        total++;
        if (nerr - e0 !== 0 || nreq - r0 !== 0) begin bad++; $display("FAIL midreset_quiet got=err%0d/req%0d exp=err0/req0", nerr - e0, nreq - r0); end
        send_str("R 5\r");
        total++;
        if (nreq - r0 !== 1) begin bad++; $display("FAIL post_reset_count got=%0d exp=1", nreq - r0); end
        check_rec("post_reset_rec", r0, 1'b1, 32'h5, 32'h0);
    endtask

    initial begin
        test_reset;
        test_write;
        test_back_to_back_reads;
        test_parse_errors;
        test_framing;
        test_full;
        test_glitch_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_debug_parser.md
# uart_debug_parser

Receives ASCII debug commands over a UART RX line and turns each well-formed line into one R/W + 32-bit address + 32-bit data record on a FIFO-style write interface. It is the receive-side counterpart of the debug printer. It accepts the same text format that the printer emits, so printer output looped back into this block reproduces the original records. It sits between an external UART-to-USB dongle and a command FIFO that feeds the debug bus master.

## Interface
- CLK_HZ, 100_000_000: system clock frequency in Hz.
- BAUD, 115200: line rate. DIV = CLK_HZ/BAUD, integer-truncated; DIV >= 4 is required.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- uart_rxd  in  1  UART RX pin, 8N1, idle high, asynchronous to clk.
- full  in  1  downstream FIFO full flag.
- w_req  out  1  one-cycle write strobe into the FIFO.
- w_rnw  out  1  1 = read command, 0 = write command.
- w_addr  out  32  parsed address word.
- w_data  out  32  parsed data word.
- err  out  1  one-cycle pulse on a framing error or parse error.
- ovf  out  1  one-cycle pulse when a complete command is dropped because full=1.

## Operation
- **Reset.** All outputs are 0. The receiver and the parser return to IDLE. A partially received byte or line is discarded.

**Receiver**
- uart_rxd passes through a 2-flop synchronizer.
- In R_IDLE, a synchronized 1->0 edge starts a counter.
- At DIV/2 the line is re-sampled. If it reads 1, this is a false start and the receiver returns to R_IDLE.
- The 8 data bits are then sampled, LSB first, at DIV-cycle intervals.
- The stop bit is sampled DIV cycles after the last data bit:
  - Stop bit = 1: the byte is valid internally for 1 cycle.
  - Stop bit = 0: err pulses, the byte is discarded, and the receiver waits for the line to read 1 before returning to R_IDLE.

**Character classes**
- Command letter: 'R'/'r' (82/114) or 'W'/'w' (87/119).
- Space: 32.
- Separator: '_' (95).
- Hex digit: '0'-'9', 'A'-'F', 'a'-'f'.
- Terminator: CR (13) or LF (10).

**Parser states: IDLE, SP1, ADDR, DATA, SKIP**
- IDLE:
  - Command letter: latch rnw, clear the address and data accumulators, go to SP1.
  - Terminator: ignored. This absorbs empty lines and the LF of a CR-LF pair.
  - Anything else: err, go to SKIP.
- SP1:
  - Space: go to ADDR.
  - Anything else: err, go to SKIP.
- ADDR:
  - Hex digit: acc = {acc[27:0], nibble}.
  - '_': ignored.
  - Space: go to DATA. Requires at least 1 address digit.
  - Terminator: complete the command. Legal only if rnw=1 and at least 1 digit has been received; data = 0.
  - A 9th digit, a violated precondition, or any other character: err, go to SKIP.
- DATA:
  - Same digit and '_' rules as ADDR.
  - Terminator with at least 1 data digit: complete the command, for both R and W.
  - Anything else, a 9th digit, or a terminator with zero data digits: err, go to SKIP.
- SKIP:
  - Discard everything until a terminator, then go to IDLE. No err is raised on the terminator itself.
- **Field width.** Fewer than 8 digits are allowed and the value is zero-extended (e.g. "W 1F 7" gives addr=0x1F, data=0x7).
- **Complete.** Registers w_rnw, w_addr and w_data, then returns to IDLE:
  - full=0: pulse w_req.
  - full=1: pulse ovf instead; the command is lost.
- **Error.** An err pulse is emitted once per offending byte or frame. A framing error in the middle of a line moves the parser to SKIP.

## Timing
- A byte becomes valid 1 cycle after its stop-bit sample.
- The parser reacts in the cycle the byte is valid.
- w_req or ovf asserts exactly 1 cycle after the terminator byte is valid, and lasts exactly 1 cycle.
- w_rnw, w_addr and w_data update in the same cycle as w_req and hold until the next completed command.
- full is sampled in the cycle the terminator byte is valid.
- The parser never stalls the receiver.
- Back-to-back bytes with no idle gap are received correctly: the start-edge search begins immediately after the stop-bit sample.
- rst asserted mid-frame: outputs clear the next cycle. The rest of the in-flight frame can be mis-framed; the parser recovers at the next terminator via SKIP.

## Test plan
Bench parameters: CLK_HZ=100, BAUD=10 (DIV=10).
1. Send "W 0000_0010 DEAD_BEEF\r" with full=0 -> exactly one w_req pulse; w_rnw=0, w_addr=0x00000010, w_data=0xDEADBEEF; err=0.
2. Send "r 1234abcd\r\n" then "R 0000_0004 CAFE_F00D\r" -> two w_req pulses: (1, 0x1234ABCD, 0) then (1, 0x00000004, 0xCAFEF00D). The LF produces no err.
3. Send "W 123456789 1\r" and "X 1\r" -> one err each (on the 9th digit and on 'X'); no w_req; a following valid "W 1 2\r" gives addr=1, data=2.
4. Send a frame with stop bit = 0 in the middle of a line, then "\r", then "W A B\r" -> err once; no w_req for the broken line; then w_req with addr=0xA, data=0xB.
5. Hold full=1 and send "W 5 6\r" -> ovf pulses once, w_req stays 0; with full=0 the next command writes normally.
6. Send a 0.3-bit low glitch on uart_rxd (false start), and separately assert rst mid-byte -> no byte is received and no err; after reset all outputs are 0 and the next valid line parses.
